// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body store.
package snake_pkg;

  localparam int XSCREEN = 160;
  localparam int YSCREEN = 120;
  localparam int XW_DEF  = 8;
  localparam int YW_DEF  = 7;
  localparam int DIM_DEF = 10;

  typedef struct packed {
    logic [XW_DEF-1:0] x;
    logic [YW_DEF-1:0] y;
  } seg_t;

  typedef enum logic {
    SC_IDLE,
    SC_SCAN
  } scan_state_e;

endpackage

// File: rtl/snake_body_store_if.sv
// Caller <-> body store bus. Tail outputs exist only with SNAKE_TAIL_TRACK_EN.
interface snake_body_store_if #(
  parameter int XW      = 8,
  parameter int YW      = 7,
  parameter int MAX_LEN = 16
);
  localparam int IW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic          init;
  logic          step;
  logic          grow;
  logic [XW-1:0] head_x_in;
  logic [YW-1:0] head_y_in;
  logic [IW-1:0] rd_idx;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic [LW-1:0] length;
  logic          full;
  logic          busy;
  logic          done;
  logic          hit;
`ifdef SNAKE_TAIL_TRACK_EN
  logic [XW-1:0] tail_x;
  logic [YW-1:0] tail_y;
  logic          tail_valid;
`endif

  modport master (
    output init, step, grow, head_x_in, head_y_in, rd_idx,
`ifdef SNAKE_TAIL_TRACK_EN
    input  tail_x, tail_y, tail_valid,
`endif
    input  rd_x, rd_y, length, full, busy, done, hit
  );

  modport slave (
    input  init, step, grow, head_x_in, head_y_in, rd_idx,
`ifdef SNAKE_TAIL_TRACK_EN
    output tail_x, tail_y, tail_valid,
`endif
    output rd_x, rd_y, length, full, busy, done, hit
  );

endinterface

// File: rtl/snake_collide_scan.sv
// Self-collision scan sequencer: walks segments 1..len-1 against the head.
//
// state   | meaning
// SC_IDLE | waiting for an accepted step
// SC_SCAN | comparing segment sc_q against the head, one per cycle
module snake_collide_scan
  import snake_pkg::*;
#(
  parameter int IW = 4,
  parameter int LW = 5
) (
  input  logic          CLOCK_50,
  input  logic          Resetn,
  input  logic          init_i,
  input  logic          start_i,
  input  logic [LW-1:0] len_i,
  input  logic          match_i,
  output logic [IW-1:0] sc_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          hit_o
);

  scan_state_e   state_q;
  logic [IW-1:0] sc_q;
  logic          busy_q;
  logic          done_q;
  logic          hit_q;
  logic          last;

  assign last = (LW'(sc_q) == len_i - LW'(1));

  // Scan FSM with registered busy/done/hit; init aborts like reset.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn || init_i) begin
      state_q <= SC_IDLE;
      sc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SC_IDLE: begin
          if (start_i) begin
            hit_q <= 1'b0;
            if (len_i > LW'(1)) begin
              state_q <= SC_SCAN;
              busy_q  <= 1'b1;
              sc_q    <= IW'(1);
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        SC_SCAN: begin
          if (match_i) begin
            hit_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= SC_IDLE;
          end else if (last) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= SC_IDLE;
          end else begin
            sc_q <= sc_q + IW'(1);
          end
        end
        default: state_q <= SC_IDLE;
      endcase
    end
  end

  assign sc_o   = sc_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hit_o  = hit_q;

endmodule

// File: rtl/snake_body_store.sv
// Circular buffer of snake segments with head insertion, growth, registered
// indexed read and post-move self-collision scan.
// Optional SNAKE_TAIL_TRACK_EN reports the vacated tail square per move.
module snake_body_store
  import snake_pkg::*;
#(
  parameter int XW       = XW_DEF,
  parameter int YW       = YW_DEF,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int X0       = 80,
  parameter int Y0       = 60,
  parameter int DIM      = DIM_DEF
) (
  input logic CLOCK_50,
  input logic Resetn,
  snake_body_store_if.slave bus
);
  localparam int IW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic [XW-1:0] sx_q [MAX_LEN];
  logic [YW-1:0] sy_q [MAX_LEN];
  logic [IW-1:0] hp_q;
  logic [LW-1:0] length_q, length_d;
  logic [XW-1:0] rd_x_q;
  logic [YW-1:0] rd_y_q;

  logic          busy, full, start, match;
  logic [IW-1:0] sc, hp_m1, rd_slot, sc_slot, tail_slot;

  assign full      = (length_q == LW'(MAX_LEN));
  assign start     = bus.step && !busy;
  assign hp_m1     = hp_q - IW'(1);
  assign rd_slot   = hp_q + bus.rd_idx;
  assign sc_slot   = hp_q + sc;
  assign tail_slot = hp_q + IW'(length_q - LW'(1));
  assign match     = (sx_q[sc_slot] == sx_q[hp_q]) && (sy_q[sc_slot] == sy_q[hp_q]);

  // Growth saturates at capacity; a full grow is an ordinary move.
  always_comb begin
    length_d = length_q;
    if (start && bus.grow && !full) length_d = length_q + LW'(1);
  end

`ifdef SNAKE_TAIL_TRACK_EN
  logic [XW-1:0] tail_x_q;
  logic [YW-1:0] tail_y_q;
  logic          tail_valid_q;

  // Capture the square a non-growing move vacates.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn || bus.init) begin
      tail_x_q     <= '0;
      tail_y_q     <= '0;
      tail_valid_q <= 1'b0;
    end else begin
      tail_valid_q <= 1'b0;
      if (start && !(bus.grow && !full)) begin
        tail_x_q     <= sx_q[tail_slot];
        tail_y_q     <= sy_q[tail_slot];
        tail_valid_q <= 1'b1;
      end
    end
  end

  assign bus.tail_x     = tail_x_q;
  assign bus.tail_y     = tail_y_q;
  assign bus.tail_valid = tail_valid_q;
`endif

  // Segment storage, head pointer, length and registered read port.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn || bus.init) begin
      hp_q     <= '0;
      length_q <= LW'(INIT_LEN);
      rd_x_q   <= '0;
      rd_y_q   <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          sx_q[i] <= XW'(X0);
          sy_q[i] <= YW'(Y0 + i * DIM);
        end else begin
          sx_q[i] <= '0;
          sy_q[i] <= '0;
        end
      end
    end else begin
      length_q <= length_d;
      rd_x_q   <= sx_q[rd_slot];
      rd_y_q   <= sy_q[rd_slot];
      if (start) begin
        hp_q        <= hp_m1;
        sx_q[hp_m1] <= bus.head_x_in;
        sy_q[hp_m1] <= bus.head_y_in;
      end
    end
  end

  snake_collide_scan #(.IW(IW), .LW(LW)) u_scan (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .init_i   (bus.init),
    .start_i  (start),
    .len_i    (length_d),
    .match_i  (match),
    .sc_o     (sc),
    .busy_o   (busy),
    .done_o   (bus.done),
    .hit_o    (bus.hit)
  );

  assign bus.rd_x   = rd_x_q;
  assign bus.rd_y   = rd_y_q;
  assign bus.length = length_q;
  assign bus.full   = full;
  assign bus.busy   = busy;

endmodule

// File: tb/tb_snake_body_store.sv
// Directed bench for snake_body_store with default parameters.
module tb_snake_body_store;
  import snake_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  int   n;
  logic [7:0] x;
  logic [6:0] y;

  seg_t init_body [4];

  always #10 clk = ~clk;

  snake_body_store_if #(.XW(8), .YW(7), .MAX_LEN(16)) bus ();

  snake_body_store #(.XW(8), .YW(7), .MAX_LEN(16), .INIT_LEN(4),
                     .X0(80), .Y0(60), .DIM(10)) dut (
    .CLOCK_50 (clk),
    .Resetn   (rstn),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_do(input int hx, input int hy, input logic g);
    bus.step      = 1'b1;
    bus.grow      = g;
    bus.head_x_in = 8'(hx);
    bus.head_y_in = 7'(hy);
    tick();
    bus.step = 1'b0;
    bus.grow = 1'b0;
  endtask

  task automatic rd_seg(input int idx, output logic [7:0] ox, output logic [6:0] oy);
    bus.rd_idx = 4'(idx);
    tick();
    ox = bus.rd_x;
    oy = bus.rd_y;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic chk_body_init(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_seg(i, x, y);
      chk($sformatf("%s_x%0d", tag, i), x, init_body[i].x);
      chk($sformatf("%s_y%0d", tag, i), y, init_body[i].y);
    end
  endtask

  initial begin
    init_body[0] = '{x: 8'd80, y: 7'd60};
    init_body[1] = '{x: 8'd80, y: 7'd70};
    init_body[2] = '{x: 8'd80, y: 7'd80};
    init_body[3] = '{x: 8'd80, y: 7'd90};

    rstn = 1'b0;
    bus.init = 1'b0;
    bus.step = 1'b0;
    bus.grow = 1'b0;
    bus.head_x_in = '0;
    bus.head_y_in = '0;
    bus.rd_idx = '0;
    tick();
    tick();
    rstn = 1'b1;

    // Reset state
    chk("rst_length", bus.length, 4);
    chk("rst_full", bus.full, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_hit", bus.hit, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rdx", bus.rd_x, 0);
`ifdef SNAKE_TAIL_TRACK_EN
    chk("rst_tail_valid", bus.tail_valid, 0);
`endif
    chk_body_init("rst");

    // Plain move up: (80,50) ahead of the initial body
    step_do(80, 50, 1'b0);
    chk("mv_busy", bus.busy, 1);
    chk("mv_length", bus.length, 4);
`ifdef SNAKE_TAIL_TRACK_EN
    chk("mv_tail_valid", bus.tail_valid, 1);
    chk("mv_tail_x", bus.tail_x, 80);
    chk("mv_tail_y", bus.tail_y, 90);
`endif
    wait_done(n);
    chk("mv_done_cycles", n, 3);
    chk("mv_hit", bus.hit, 0);
    chk("mv_busy_end", bus.busy, 0);
    tick();
    chk("mv_done_pulse", bus.done, 0);
    rd_seg(0, x, y);
    chk("mv_idx0_y", y, 50);
    rd_seg(3, x, y);
    chk("mv_idx3_x", x, 80);
    chk("mv_idx3_y", y, 80);

    // Move to (80,40), then a grow step while busy must be ignored
    step_do(80, 40, 1'b0);
    chk("ign_busy", bus.busy, 1);
    bus.step = 1'b1;
    bus.grow = 1'b1;
    bus.head_x_in = 8'd0;
    bus.head_y_in = 7'd0;
    tick();
    bus.step = 1'b0;
    bus.grow = 1'b0;
    chk("ign_length", bus.length, 4);
`ifdef SNAKE_TAIL_TRACK_EN
    chk("ign_tail_valid", bus.tail_valid, 0);
`endif
    wait_done(n);
    chk("ign_done_cycles", n, 2);
    chk("ign_hit", bus.hit, 0);
    rd_seg(0, x, y);
    chk("ign_idx0_x", x, 80);
    chk("ign_idx0_y", y, 40);
    rd_seg(1, x, y);
    chk("ign_idx1_y", y, 50);
    rd_seg(3, x, y);
    chk("ign_idx3_y", y, 70);

    // Head onto segment 1: early exit after one compare
    step_do(80, 40, 1'b0);
    wait_done(n);
    chk("hit1_cycles", n, 1);
    chk("hit1_hit", bus.hit, 1);
    chk("hit1_busy", bus.busy, 0);
    tick();
    chk("hit1_hold", bus.hit, 1);
    chk("hit1_done_pulse", bus.done, 0);

    // Body (80,40),(80,40),(80,50),(80,60); head (80,50) meets idx 3
    step_do(80, 50, 1'b0);
    chk("loop_hit_clr", bus.hit, 0);
    chk("loop_busy", bus.busy, 1);
    wait_done(n);
    chk("loop_cycles", n, 3);
    chk("loop_hit", bus.hit, 1);
    chk("loop_busy_end", bus.busy, 0);

    // init in the middle of a scan
    step_do(10, 10, 1'b0);
    tick();
    chk("init_pre_busy", bus.busy, 1);
    bus.init = 1'b1;
    tick();
    bus.init = 1'b0;
    chk("init_busy", bus.busy, 0);
    chk("init_hit", bus.hit, 0);
    chk("init_done", bus.done, 0);
    chk("init_length", bus.length, 4);
    chk_body_init("init");

    // Grow twelve times to capacity
    for (int i = 0; i < 12; i++) begin
      step_do(100 + i, 5, 1'b1);
      if (i == 0) begin
        chk("grow_len5", bus.length, 5);
`ifdef SNAKE_TAIL_TRACK_EN
        chk("grow_tail_valid", bus.tail_valid, 0);
`endif
      end
      wait_done(n);
    end
    chk("full_length", bus.length, 16);
    chk("full_flag", bus.full, 1);

    // Grow while full saturates and drops the tail
    step_do(1, 2, 1'b1);
    chk("sat_length", bus.length, 16);
`ifdef SNAKE_TAIL_TRACK_EN
    chk("sat_tail_valid", bus.tail_valid, 1);
    chk("sat_tail_x", bus.tail_x, 80);
    chk("sat_tail_y", bus.tail_y, 90);
`endif
    wait_done(n);
    chk("sat_cycles", n, 15);
    chk("sat_hit", bus.hit, 0);
    rd_seg(0, x, y);
    chk("sat_idx0_x", x, 1);
    chk("sat_idx0_y", y, 2);
    rd_seg(1, x, y);
    chk("sat_idx1_x", x, 111);
    rd_seg(15, x, y);
    chk("sat_idx15_x", x, 80);
    chk("sat_idx15_y", y, 80);
    chk("sat_full", bus.full, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snake_body_store.md
Name: snake_body_store

Overview:
- Parametrised storage for snake body segment coordinates, replacing the fixed 4-segment replicated-coordinate shift registers.
- Circular buffer of up to MAX_LEN (x,y) segments with a variable length.
- Supports head insertion on move and growth on apple.
- Provides a registered indexed read port for the draw/erase FSM and a sequential self-collision scan after every move.

Parameters:
- XW, 8, x coordinate width (160-wide screen).
- YW, 7, y coordinate width (120-high screen).
- MAX_LEN, 16, segment capacity; power of two, 4..64.
- INIT_LEN, 4, length after reset/init; 1..MAX_LEN.
- X0, 80, initial head x.
- Y0, 60, initial head y.
- DIM, 10, segment pitch in pixels; initial segment i is at (X0, Y0 + i*DIM).
- Derived: IW = $clog2(MAX_LEN) (index width); LW = $clog2(MAX_LEN+1) (length width).

Ports:
- CLOCK_50  in  1  system clock.
- Resetn  in  1  reset, synchronous, active-low; clock CLOCK_50.
- init  in  1  reload the initial body; same effect as reset.
- step  in  1  one-cycle move request; new head = (head_x_in, head_y_in).
- grow  in  1  sampled with step: keep the tail, length+1.
- head_x_in  in  XW  new head x.
- head_y_in  in  YW  new head y.
- rd_idx  in  IW  segment index, 0 = head.
- rd_x  out  XW  x of segment rd_idx, registered.
- rd_y  out  YW  y of segment rd_idx, registered.
- length  out  LW  current segment count.
- full  out  1  length == MAX_LEN.
- busy  out  1  collision scan in progress.
- done  out  1  one-cycle pulse at scan end.
- hit  out  1  new head matched a body segment; valid from done until the next step/init.

Behaviour:
- Storage: MAX_LEN x (XW+YW) registers plus head pointer hp (IW bits). Physical slot of logical index k is (hp + k) mod MAX_LEN; wrap is natural overflow.
- Reset (Resetn=0) or init=1, effective next edge:
  - hp=0; length=INIT_LEN; slot i = (X0, Y0+i*DIM) for i < INIT_LEN; unused slots = 0.
  - busy=0, done=0, hit=0, rd_x=0, rd_y=0.
  - init aborts any scan; reset has priority over init.
- Step accepted only when step=1 and busy=0. Step while busy is ignored with no state change.
- On an accepted step at edge t:
  - hp <= hp-1; slot(hp-1) <= head inputs.
  - If grow and !full: length+1. Otherwise length is unchanged and the old tail slot is logically dropped.
  - grow while full behaves as a plain move (saturation).
  - hit <= 0; busy <= 1 from edge t+1, unless length after the step is 1, in which case done pulses at t+1 with hit=0 and busy stays 0.
- Scan:
  - Internal counter sc runs 1..length-1, one compare per cycle of segment sc against segment 0, both x and y equal.
  - On match: hit<=1, done pulses, busy<=0 the same edge (early exit).
  - On reaching sc=length-1 without a match: done pulses, busy<=0, hit=0.
  - Worst-case scan latency is length-1 cycles after the step.
- Read: rd_x/rd_y <= slot(hp+rd_idx) every edge, 1-cycle latency. rd_idx >= length returns stale slot contents (don't care); the caller bounds it.
- States: IDLE, SCAN. Transitions:
  - IDLE->SCAN on an accepted step with length>1.
  - SCAN->IDLE on hit or last index.
  - Any state->IDLE on reset/init.

Optional Feature:
- SNAKE_TAIL_TRACK_EN defined: adds outputs tail_x (XW), tail_y (YW), tail_valid (1).
  - On an accepted non-growing step (including grow while full), the pre-step tail coordinate is registered and tail_valid pulses one cycle at t+1, so the erase FSM clears only the vacated square.
  - Outputs reset to 0.
- Undefined: the ports and registers are absent; the caller erases the whole body.

Decomposition:
- Package snake_pkg: XSCREEN=160, YSCREEN=120, default XW/YW/DIM, and a segment struct typedef {x, y}.
- One natural sub-module: snake_collide_scan, holding the IDLE/SCAN FSM and the sc counter; it takes length and a compare-result input and drives the scan-index, busy, done and hit outputs.

Test Plan:
- Reset with defaults -> length=4; rd_idx 0..3 gives (80,60),(80,70),(80,80),(80,90); busy=0, hit=0.
- step, head_in=(80,50), grow=0 -> length=4; idx0=(80,50), idx3=(80,80); done after 3 cycles with hit=0; with the macro, tail_valid pulses and tail=(80,90).
- 12 steps with grow=1 from reset -> length saturates at 16, full=1; a 13th grow step leaves length=16 and the head updates.
- Steps forming a loop with head_in equal to the segment at idx 3 -> done pulses 3 cycles after the step, hit=1, busy falls the same edge.
- step asserted while busy=1 -> ignored; hp, length and slots unchanged.
- init pulsed mid-scan -> next cycle busy=0, hit=0, length=4, initial coordinates restored.
